branch_predictor_unit: RTL and testbench

- Parametrised, multi-lane direction predictor for the fetch front end, covering bimodal, gshare and GAg schemes.
- The scheme is selected by parameter instead of a compile-time define.
- The NextPC stage issues a lookup; the Fetch stage receives per-lane taken predictions one cycle later.
- Owns a speculative global history register (GHR) with commit-time counter training, misprediction recovery, and a post-reset table-initialisation sequencer.

---
 rtl/branch_predictor_unit.sv | 262 ++++++++++++++++++++++++++
 tb/tb_branch_predictor_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_unit
// Brief    : Multi-lane 2-bit-counter direction predictor for the fetch front
//            end. Supports bimodal, gshare and GAg indexing. It keeps a
//            speculative global history register, trains counters at commit,
//            repairs history on a misprediction, and clears the table after
//            reset with an init sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor_unit #(
    parameter int FETCH_WIDTH    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int PC_LSB         = 2,
    parameter int PHT_INDEX_BITS = 10,
    parameter int GHR_BITS       = 10,
    parameter int MODE           = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      ready,
    input  logic                      lu_valid,
    input  logic [ADDR_WIDTH-1:0]     lu_pc,
    output logic                      pred_valid,
    output logic [FETCH_WIDTH-1:0]    pred_taken,
    output logic [GHR_BITS-1:0]       pred_ghr,
    input  logic                      spec_valid,
    input  logic                      spec_taken,
    input  logic                      upd_valid,
    input  logic [ADDR_WIDTH-1:0]     upd_pc,
    input  logic [GHR_BITS-1:0]       upd_ghr,
    input  logic                      upd_taken,
    input  logic                      upd_mispred
);

    localparam int c_PHT_DEPTH    = 1 << PHT_INDEX_BITS;
    // PC bits that can influence a lane index once the lane offset is added.
    localparam int c_LO_W         = PC_LSB + PHT_INDEX_BITS;
    localparam int c_MODE_BIMODAL = 0;
    localparam int c_MODE_GSHARE  = 1;
    localparam int c_MODE_GAG     = 2;
    localparam logic [1:0] c_CTR_INIT = 2'b01;
    localparam logic [PHT_INDEX_BITS-1:0] c_LAST_ENTRY = {PHT_INDEX_BITS{1'b1}};

    // Reject parameter combinations the indexing logic cannot support.
    generate
        if (GHR_BITS > PHT_INDEX_BITS) begin : g_err_ghr_len
            $error("branch_predictor_unit: GHR_BITS must not exceed PHT_INDEX_BITS");
        end
        if (GHR_BITS < 2) begin : g_err_ghr_min
            $error("branch_predictor_unit: GHR_BITS must be at least 2");
        end
        if (MODE != c_MODE_BIMODAL && MODE != c_MODE_GSHARE && MODE != c_MODE_GAG) begin : g_err_mode
            $error("branch_predictor_unit: MODE must be 0, 1 or 2");
        end
        if (c_LO_W > ADDR_WIDTH) begin : g_err_addr
            $error("branch_predictor_unit: ADDR_WIDTH too small for PC_LSB + PHT_INDEX_BITS");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer: INIT walks every entry once, then RUN serves traffic.
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic                         w_ready;
    logic [PHT_INDEX_BITS-1:0]    r_init_cnt;

    // State register; reset always restarts the table walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave INIT after the last entry has been written.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == c_LAST_ENTRY) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ready = 1'b1;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // Init entry pointer, advancing one entry per INIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
        end
    end

    assign ready = w_ready;

    // Lookups, updates and history shifts only count once RUN is reached.
    logic w_run;
    logic w_lu_accept;
    logic w_upd_accept;

    assign w_run        = (r_state == ST_RUN);
    assign w_lu_accept  = w_run && lu_valid;
    assign w_upd_accept = w_run && upd_valid;

    // ------------------------------------------------------------------
    // Global history
    // ------------------------------------------------------------------
    logic [GHR_BITS-1:0] r_ghr;

    // A mispredict rebuilds history from the committed snapshot and wins over
    // a same-cycle speculative shift, which is based on the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (w_upd_accept && upd_mispred) begin
            r_ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken};
        end else if (w_run && spec_valid) begin
            r_ghr <= {r_ghr[GHR_BITS-2:0], spec_taken};
        end
    end

    // ------------------------------------------------------------------
    // Index generation
    // ------------------------------------------------------------------
    logic [PHT_INDEX_BITS-1:0]                    w_ghr_z;
    logic [PHT_INDEX_BITS-1:0]                    w_upd_ghr_z;
    logic [FETCH_WIDTH-1:0][c_LO_W-1:0]           w_lane_lo;
    logic [FETCH_WIDTH-1:0][PHT_INDEX_BITS-1:0]   w_lane_pcidx;
    logic [FETCH_WIDTH-1:0][PHT_INDEX_BITS-1:0]   w_lu_idx;
    logic [PHT_INDEX_BITS-1:0]                    w_upd_pcidx;
    logic [PHT_INDEX_BITS-1:0]                    w_upd_idx;

    assign w_ghr_z     = PHT_INDEX_BITS'(r_ghr);
    assign w_upd_ghr_z = PHT_INDEX_BITS'(upd_ghr);
    assign w_upd_pcidx = upd_pc[PC_LSB +: PHT_INDEX_BITS];

    // Each lane adds its 4-byte offset to the low PC bits; carries above the
    // index field cannot reach the index, so the sum is kept narrow.
    generate
        for (genvar l = 0; l < FETCH_WIDTH; l++) begin : g_lane
            assign w_lane_lo[l]    = lu_pc[c_LO_W-1:0] + c_LO_W'(4 * l);
            assign w_lane_pcidx[l] = w_lane_lo[l][c_LO_W-1:PC_LSB];
            if (MODE == c_MODE_BIMODAL) begin : g_lu_bimodal
                assign w_lu_idx[l] = w_lane_pcidx[l];
            end else if (MODE == c_MODE_GSHARE) begin : g_lu_gshare
                assign w_lu_idx[l] = w_lane_pcidx[l] ^ w_ghr_z;
            end else begin : g_lu_gag
                assign w_lu_idx[l] = w_ghr_z + PHT_INDEX_BITS'(l);
            end
        end

        if (MODE == c_MODE_BIMODAL) begin : g_upd_bimodal
            assign w_upd_idx = w_upd_pcidx;
        end else if (MODE == c_MODE_GSHARE) begin : g_upd_gshare
            assign w_upd_idx = w_upd_pcidx ^ w_upd_ghr_z;
        end else begin : g_upd_gag
            assign w_upd_idx = w_upd_ghr_z;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pattern history table: one write port, FETCH_WIDTH read ports
    // ------------------------------------------------------------------
    logic [1:0]                   r_pht [c_PHT_DEPTH];
    logic [1:0]                   w_upd_cur;
    logic [1:0]                   w_upd_next;
    logic                         w_pht_we;
    logic [PHT_INDEX_BITS-1:0]    w_pht_waddr;
    logic [1:0]                   w_pht_wdata;

    assign w_upd_cur = r_pht[w_upd_idx];

    // Saturating 2-bit counter step toward the resolved direction.
    always_comb begin
        w_upd_next = w_upd_cur;
        if (upd_taken) begin
            if (w_upd_cur != 2'b11) begin
                w_upd_next = w_upd_cur + 2'd1;
            end
        end else begin
            if (w_upd_cur != 2'b00) begin
                w_upd_next = w_upd_cur - 2'd1;
            end
        end
    end

    // Write-port arbitration: INIT owns the port, RUN gives it to training.
    always_comb begin
        w_pht_we    = 1'b0;
        w_pht_waddr = w_upd_idx;
        w_pht_wdata = w_upd_next;
        if (!rst) begin
            if (r_state == ST_INIT) begin
                w_pht_we    = 1'b1;
                w_pht_waddr = r_init_cnt;
                w_pht_wdata = c_CTR_INIT;
            end else if (upd_valid) begin
                w_pht_we    = 1'b1;
            end
        end
    end

    // Table write; contents are defined by the INIT walk, not by reset.
    always_ff @(posedge clk) begin
        if (w_pht_we) begin
            r_pht[w_pht_waddr] <= w_pht_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Registered prediction outputs
    // ------------------------------------------------------------------
    logic                      r_pred_valid;
    logic [FETCH_WIDTH-1:0]    r_pred_taken;
    logic [GHR_BITS-1:0]       r_pred_ghr;

    // Capture counter MSBs and the pre-shift history for accepted lookups.
    // Reading the pre-edge table gives the pre-update value on collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= '0;
            r_pred_ghr   <= '0;
        end else begin
            r_pred_valid <= w_lu_accept;
            if (w_lu_accept) begin
                r_pred_ghr <= r_ghr;
                for (int l = 0; l < FETCH_WIDTH; l++) begin
                    r_pred_taken[l] <= r_pht[w_lu_idx[l]][1];
                end
            end
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;
    assign pred_ghr   = r_pred_ghr;

    // Bits that a given MODE or parameter set leaves unconsumed.
    logic w_unused;
    assign w_unused = ^{lu_pc, upd_pc, upd_ghr, w_lane_lo, w_lane_pcidx,
                        w_upd_pcidx, w_ghr_z, w_upd_ghr_z, w_upd_accept};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor_unit
// Brief    : Drives bimodal, gshare and GAg instances with a shared directed
//            stimulus. A behavioural model is compared on every cycle, and
//            literal expectations pin the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_unit;

    localparam int c_NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, lu_valid, spec_valid, spec_taken, upd_valid, upd_taken, upd_mispred;
    logic [31:0] lu_pc, upd_pc;
    logic [9:0]  upd_ghr;

    logic       bim_ready, bim_pv, gsh_ready, gsh_pv, gag_ready, gag_pv;
    logic [1:0] bim_pt, gsh_pt, gag_pt;
    logic [3:0] bim_pg, gag_pg;
    logic [9:0] gsh_pg;

    branch_predictor_unit #(.FETCH_WIDTH(2), .ADDR_WIDTH(32), .PC_LSB(2),
        .PHT_INDEX_BITS(4), .GHR_BITS(4), .MODE(0)) u_bim (
        .clk(clk), .rst(rst), .ready(bim_ready), .lu_valid(lu_valid), .lu_pc(lu_pc),
        .pred_valid(bim_pv), .pred_taken(bim_pt), .pred_ghr(bim_pg),
        .spec_valid(spec_valid), .spec_taken(spec_taken), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_ghr(upd_ghr[3:0]), .upd_taken(upd_taken), .upd_mispred(upd_mispred));

    branch_predictor_unit #(.FETCH_WIDTH(2), .ADDR_WIDTH(32), .PC_LSB(2),
        .PHT_INDEX_BITS(10), .GHR_BITS(10), .MODE(1)) u_gsh (
        .clk(clk), .rst(rst), .ready(gsh_ready), .lu_valid(lu_valid), .lu_pc(lu_pc),
        .pred_valid(gsh_pv), .pred_taken(gsh_pt), .pred_ghr(gsh_pg),
        .spec_valid(spec_valid), .spec_taken(spec_taken), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken), .upd_mispred(upd_mispred));

    branch_predictor_unit #(.FETCH_WIDTH(2), .ADDR_WIDTH(32), .PC_LSB(2),
        .PHT_INDEX_BITS(4), .GHR_BITS(4), .MODE(2)) u_gag (
        .clk(clk), .rst(rst), .ready(gag_ready), .lu_valid(lu_valid), .lu_pc(lu_pc),
        .pred_valid(gag_pv), .pred_taken(gag_pt), .pred_ghr(gag_pg),
        .spec_valid(spec_valid), .spec_taken(spec_taken), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_ghr(upd_ghr[3:0]), .upd_taken(upd_taken), .upd_mispred(upd_mispred));

    // Instance outputs gathered for uniform comparison.
    logic       a_ready [c_NI];
    logic       a_pv    [c_NI];
    logic [1:0] a_pt    [c_NI];
    logic [9:0] a_pg    [c_NI];
    assign a_ready[0] = bim_ready; assign a_pv[0] = bim_pv; assign a_pt[0] = bim_pt; assign a_pg[0] = {6'd0, bim_pg};
    assign a_ready[1] = gsh_ready; assign a_pv[1] = gsh_pv; assign a_pt[1] = gsh_pt; assign a_pg[1] = gsh_pg;
    assign a_ready[2] = gag_ready; assign a_pv[2] = gag_pv; assign a_pt[2] = gag_pt; assign a_pg[2] = {6'd0, gag_pg};

    string c_NAME [c_NI] = '{"bim", "gsh", "gag"};
    int    m_mode [c_NI] = '{0, 1, 2};
    int    m_pb   [c_NI] = '{4, 10, 4};
    int    m_gb   [c_NI] = '{4, 10, 4};

    int         m_pht [c_NI][1024];
    int         m_ghr [c_NI];
    int         m_init_left [c_NI];
    bit         e_pv [c_NI];
    logic [1:0] e_pt [c_NI];
    int         e_pg [c_NI];
    bit         started = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model indexing: plain arithmetic on the PC and history values.
    function automatic int pc_index(int k, logic [31:0] pc);
        return int'(pc >> 2) & ((1 << m_pb[k]) - 1);
    endfunction

    function automatic int lookup_index(int k, logic [31:0] pc, int lane);
        int pi;
        pi = pc_index(k, pc + 32'(4 * lane));
        case (m_mode[k])
            0:       return pi;
            1:       return pi ^ m_ghr[k];
            default: return (m_ghr[k] + lane) & ((1 << m_pb[k]) - 1);
        endcase
    endfunction

    function automatic int update_index(int k);
        int g;
        g = int'(upd_ghr) & ((1 << m_gb[k]) - 1);
        case (m_mode[k])
            0:       return pc_index(k, upd_pc);
            1:       return pc_index(k, upd_pc) ^ g;
            default: return g;
        endcase
    endfunction

    // Behavioural model, advanced on every rising edge.
    always @(posedge clk) begin
        int u;
        int mask;
        for (int k = 0; k < c_NI; k++) begin
            mask = (1 << m_gb[k]) - 1;
            if (rst) begin
                started        = 1'b1;
                m_init_left[k] = 1 << m_pb[k];
                m_ghr[k]       = 0;
                e_pv[k]        = 1'b0;
                e_pt[k]        = 2'b00;
                e_pg[k]        = 0;
                for (int i = 0; i < 1024; i++) m_pht[k][i] = 1;
            end else if (m_init_left[k] > 0) begin
                m_init_left[k]--;
                e_pv[k] = 1'b0;
            end else begin
                e_pv[k] = lu_valid;
                if (lu_valid) begin
                    for (int ln = 0; ln < 2; ln++)
                        e_pt[k][ln] = (m_pht[k][lookup_index(k, lu_pc, ln)] >= 2);
                    e_pg[k] = m_ghr[k];
                end
                if (upd_valid) begin
                    u = update_index(k);
                    if (upd_taken) m_pht[k][u] = (m_pht[k][u] == 3) ? 3 : m_pht[k][u] + 1;
                    else           m_pht[k][u] = (m_pht[k][u] == 0) ? 0 : m_pht[k][u] - 1;
                end
                if (upd_valid && upd_mispred)
                    m_ghr[k] = ((int'(upd_ghr) << 1) | int'(upd_taken)) & mask;
                else if (spec_valid)
                    m_ghr[k] = ((m_ghr[k] << 1) | int'(spec_taken)) & mask;
            end
        end
    end

    // Compare every output of every instance against the model each cycle.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < c_NI; k++) begin
                check({c_NAME[k], ".ready"},      32'(a_ready[k]), 32'(m_init_left[k] == 0));
                check({c_NAME[k], ".pred_valid"}, 32'(a_pv[k]),    32'(e_pv[k]));
                check({c_NAME[k], ".pred_taken"}, 32'(a_pt[k]),    32'(e_pt[k]));
                check({c_NAME[k], ".pred_ghr"},   32'(a_pg[k]),    32'(e_pg[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        lu_valid = 1'b1;
        lu_pc    = pc;
        tick();
        lu_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic [9:0] g, input logic t, input logic mp);
        upd_valid   = 1'b1;
        upd_pc      = pc;
        upd_ghr     = g;
        upd_taken   = t;
        upd_mispred = mp;
        tick();
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
    endtask

    // Counts cycles with ready low on the small tables, then the large one.
    task automatic count_init(input string tag);
        int n;
        n = 0;
        while (!bim_ready && n < 2000) begin n++; tick(); end
        check({tag, ".bim_init_cycles"}, 32'(n), 32'd16);
        while (!gsh_ready && n < 2000) begin n++; tick(); end
        check({tag, ".gsh_init_cycles"}, 32'(n), 32'd1024);
    endtask

    initial begin
        rst = 1'b1; lu_valid = 1'b0; lu_pc = '0; spec_valid = 1'b0; spec_taken = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0; upd_mispred = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        count_init("reset");

        // First lookup after INIT sees weakly-not-taken counters.
        lookup(32'h0);
        check("first.bim_taken", 32'(bim_pt), 32'h0);
        check("first.bim_valid", 32'(bim_pv), 32'h1);
        check("first.gsh_ghr",   32'(gsh_pg), 32'h0);

        // Bimodal training and saturation.
        repeat (2) update(32'h40, 10'h0, 1'b1, 1'b0);
        lookup(32'h40);
        check("bim.trained", 32'(bim_pt), 32'h1);
        repeat (4) update(32'h40, 10'h0, 1'b0, 1'b0);
        lookup(32'h40);
        check("bim.saturate_low", 32'(bim_pt), 32'h0);
        tick();
        check("bim.valid_drops", 32'(bim_pv), 32'h0);

        // Collision: counter at 1, lookup and taken update in the same cycle.
        update(32'h40, 10'h0, 1'b1, 1'b0);
        lu_valid = 1'b1; lu_pc = 32'h40;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_ghr = 10'h0; upd_taken = 1'b1;
        tick();
        lu_valid = 1'b0; upd_valid = 1'b0;
        check("collide.pre_update", 32'(bim_pt), 32'h0);
        lookup(32'h40);
        check("collide.after", 32'(bim_pt), 32'h1);

        // Index wrap: lane 1 of pc 0x3C lands on entry 0.
        repeat (2) update(32'h0, 10'h0, 1'b1, 1'b0);
        lookup(32'h3C);
        check("wrap.bim", 32'(bim_pt), 32'h2);

        // Speculative history 1,0,1.
        spec_valid = 1'b1;
        spec_taken = 1'b1; tick();
        spec_taken = 1'b0; tick();
        spec_taken = 1'b1; tick();
        spec_valid = 1'b0;
        lookup(32'h100);
        check("spec.gsh_ghr", 32'(gsh_pg), 32'h005);
        check("spec.bim_ghr", 32'(bim_pg), 32'h5);

        // Recovery beats a same-cycle speculative shift.
        spec_valid = 1'b1; spec_taken = 1'b0;
        update(32'h200, 10'h02A, 1'b1, 1'b1);
        spec_valid = 1'b0;
        lookup(32'h0);
        check("recover.gsh_ghr", 32'(gsh_pg), 32'h055);
        update(32'h0, 10'h3FF, 1'b1, 1'b0);
        lookup(32'h0);
        check("no_mispred.gsh_ghr", 32'(gsh_pg), 32'h055);

        // Gshare XOR indexing: train entry 0x10^0x55 via the committed snapshot.
        repeat (2) update(32'h40, 10'h055, 1'b1, 1'b0);
        lookup(32'h40);
        check("gshare.xor_index", 32'(gsh_pt), 32'h1);

        // Reset in RUN, then again five cycles into INIT.
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        count_init("rerun");
        lookup(32'h40);
        check("reinit.entry0", 32'(bim_pt), 32'h0);
        lookup(32'h3C);
        check("reinit.wrap", 32'(bim_pt), 32'h0);
        update(32'h40, 10'h0, 1'b1, 1'b0);
        lookup(32'h40);
        check("reinit.weak_nt", 32'(bim_pt), 32'h1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
